seed_index_aligner: RTL and testbench

SEED_INDEX_ALIGNER -- requirements
Module: seed_index_aligner

---
 rtl/seed_index_aligner.sv | 240 ++++++++++++++++++++++++
 tb/tb_seed_index_aligner.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_index_aligner.sv
// -----------------------------------------------------------------------------
// seed_index_aligner
//
// Purpose
//   Builds a small seed index over a packed 2-bit DNA reference, then looks up
//   every seed of a short read in that index and reports candidate alignment
//   positions. Bases are encoded A=00, G=01, C=10, T=11. Base i of a packed
//   vector sits at bits [2i+1:2i].
//
//   Index: four buckets, one per base value. The entry for reference position
//   p holds {seed(p), p}, where seed(p) is the SEED_BASES bases starting at p.
//   The entry goes into the bucket of base p. A full bucket drops the entry and
//   sets the sticky overflow flag.
//
//   Search: for each read offset o, scan the bucket of read base o, one entry
//   per cycle. An empty bucket still costs one cycle. A hit is an entry whose
//   seed equals read seed(o), with pos >= o and pos-o <= REF_BASES-WIN_BASES.
//
// Optional feature
//   SEED_DEDUP_EN : when defined, a per-query seen map suppresses a hit whose
//                   hit_pos was already reported in the same query. When it is
//                   not defined, every qualifying match is reported.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-low
//   ref_in     in   2*REF_BASES   reference, captured on load
//   read_in    in   2*READ_BASES  short read, captured on an accepted query
//   load       in   pulse: capture ref_in and rebuild the index (any state)
//   query      in   pulse: start a search (accepted in READY only)
//   busy       out  high while building or searching
//   ready      out  high in READY only
//   hit_valid  out  one-cycle pulse per reported hit
//   hit_pos    out  POS_W         candidate alignment position
//   hit_seq    out  2*WIN_BASES   reference bases hit_pos .. hit_pos+WIN_BASES-1
//   hit_count  out  8             hits in current/last query, saturating at 255
//   done       out  one-cycle pulse at the end of a search
//   overflow   out  sticky: an index entry was dropped during the last build
//   dbg_state  out  3             current FSM state (IDLE..DONE)
// -----------------------------------------------------------------------------
module seed_index_aligner #(
    parameter int REF_BASES  = 50,
    parameter int READ_BASES = 8,
    parameter int SEED_BASES = 4,
    parameter int WIN_BASES  = 10,
    parameter int BKT_DEPTH  = 64,
    parameter int POS_W      = $clog2(REF_BASES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*REF_BASES-1:0]  ref_in,
    input  logic [2*READ_BASES-1:0] read_in,
    input  logic                    load,
    input  logic                    query,
    output logic                    busy,
    output logic                    ready,
    output logic                    hit_valid,
    output logic [POS_W-1:0]        hit_pos,
    output logic [2*WIN_BASES-1:0]  hit_seq,
    output logic [7:0]              hit_count,
    output logic                    done,
    output logic                    overflow,
    output logic [2:0]              dbg_state
);
    localparam int SEED_W = 2 * SEED_BASES;
    localparam int ENT_W  = SEED_W + POS_W;
    localparam int CNT_W  = $clog2(BKT_DEPTH + 1);
    localparam int IDX_W  = (BKT_DEPTH > 1) ? $clog2(BKT_DEPTH) : 1;
    localparam int OFF_W  = (READ_BASES > SEED_BASES) ? $clog2(READ_BASES - SEED_BASES + 1) : 1;

    localparam logic [POS_W-1:0] LAST_P  = POS_W'(REF_BASES - SEED_BASES);
    localparam logic [OFF_W-1:0] LAST_O  = OFF_W'(READ_BASES - SEED_BASES);
    localparam logic [POS_W:0]   MAX_REL = (POS_W + 1)'(REF_BASES - WIN_BASES);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(BKT_DEPTH);

    typedef enum logic [2:0] {IDLE, BUILD, READY, SEARCH, DONE} state_t;

    // load and query are single-cycle command pulses with no backpressure.
    // load is honoured in every state and restarts the build. query is
    // honoured only while ready is high, and load beats query in that cycle.
    // A command given at any other time is simply dropped.

    state_t                  state_q, state_d;
    logic [2*REF_BASES-1:0]  ref_q;
    logic [2*READ_BASES-1:0] read_q;
    logic [POS_W-1:0]        p_q;
    logic [OFF_W-1:0]        o_q;
    logic [CNT_W-1:0]        e_q;
    logic [CNT_W-1:0]        cnt_q [4];
    logic [ENT_W-1:0]        mem_q [4*BKT_DEPTH];
    logic                    overflow_q;
    logic                    hit_valid_q;
    logic [POS_W-1:0]        hit_pos_q;
    logic [2*WIN_BASES-1:0]  hit_seq_q;
    logic [7:0]              hit_count_q;

    // Build-side view of the current reference position.
    logic [1:0]        bld_base;
    logic [SEED_W-1:0] bld_seed;
    logic              bld_room;

    assign bld_base = ref_q[2*p_q +: 2];
    assign bld_seed = ref_q[2*p_q +: SEED_W];
    assign bld_room = (cnt_q[bld_base] < FULL);

    // Search-side view of the current (offset, entry) pair.
    logic [1:0]        srch_base;
    logic [SEED_W-1:0] read_seed;
    logic [CNT_W-1:0]  srch_cnt;
    logic [ENT_W-1:0]  entry;
    logic [SEED_W-1:0] ent_seed;
    logic [POS_W:0]    ent_pos_x;
    logic [POS_W:0]    off_x;
    logic [POS_W:0]    rel_pos;
    logic              ent_match;
    logic              report;
    logic              last_entry;

    assign srch_base  = read_q[2*o_q +: 2];
    assign read_seed  = read_q[2*o_q +: SEED_W];
    assign srch_cnt   = cnt_q[srch_base];
    assign entry      = mem_q[{srch_base, e_q[IDX_W-1:0]}];
    assign ent_seed   = entry[ENT_W-1:POS_W];
    assign ent_pos_x  = {1'b0, entry[POS_W-1:0]};
    assign off_x      = (POS_W + 1)'(o_q);
    // One extra bit so that pos < o can never wrap into a legal position.
    assign rel_pos    = ent_pos_x - off_x;
    assign ent_match  = (srch_cnt != '0) && (ent_seed == read_seed) &&
                        (ent_pos_x >= off_x) && (rel_pos <= MAX_REL);
    // An empty bucket is treated as a single non-matching slot.
    assign last_entry = (srch_cnt == '0) || (e_q == srch_cnt - 1'b1);

`ifdef SEED_DEDUP_EN
    logic [REF_BASES-1:0] seen_q;
    assign report = ent_match && !seen_q[rel_pos[POS_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            seen_q <= '0;
        end else if (!load && state_q == READY && query) begin
            seen_q <= '0;
        end else if (!load && state_q == SEARCH && report) begin
            seen_q[rel_pos[POS_W-1:0]] <= 1'b1;
        end
    end
`else
    assign report = ent_match;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = BUILD;
            BUILD:   if (load) state_d = BUILD;
                     else if (p_q == LAST_P) state_d = READY;
            READY:   if (load) state_d = BUILD;
                     else if (query) state_d = SEARCH;
            SEARCH:  if (load) state_d = BUILD;
                     else if (last_entry && o_q == LAST_O) state_d = DONE;
            DONE:    if (load) state_d = BUILD;
                     else state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ref_q       <= '0;
            read_q      <= '0;
            p_q         <= '0;
            o_q         <= '0;
            e_q         <= '0;
            for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
            overflow_q  <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_pos_q   <= '0;
            hit_seq_q   <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hit_valid_q <= 1'b0;
            if (load) begin
                ref_q      <= ref_in;
                p_q        <= '0;
                overflow_q <= 1'b0;
                for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
            end else begin
                case (state_q)
                    BUILD: begin
                        if (bld_room) cnt_q[bld_base] <= cnt_q[bld_base] + 1'b1;
                        else          overflow_q      <= 1'b1;
                        p_q <= p_q + 1'b1;
                    end
                    READY: begin
                        if (query) begin
                            read_q      <= read_in;
                            o_q         <= '0;
                            e_q         <= '0;
                            hit_count_q <= '0;
                        end
                    end
                    SEARCH: begin
                        if (report) begin
                            hit_valid_q <= 1'b1;
                            hit_pos_q   <= rel_pos[POS_W-1:0];
                            hit_seq_q   <= ref_q[2*rel_pos[POS_W-1:0] +: 2*WIN_BASES];
                            if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
                        end
                        if (last_entry) begin
                            e_q <= '0;
                            o_q <= o_q + 1'b1;
                        end else begin
                            e_q <= e_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bucket storage is never cleared; the counts define what is valid.
    always_ff @(posedge clk) begin
        if (reset && !load && state_q == BUILD && bld_room) begin
            mem_q[{bld_base, cnt_q[bld_base][IDX_W-1:0]}] <= {bld_seed, p_q};
        end
    end

    assign busy      = (state_q == BUILD) || (state_q == SEARCH);
    assign ready     = (state_q == READY);
    assign done      = (state_q == DONE);
    assign hit_valid = hit_valid_q;
    assign hit_pos   = hit_pos_q;
    assign hit_seq   = hit_seq_q;
    assign hit_count = hit_count_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seed_index_aligner.sv
module tb_seed_index_aligner;
  localparam int RB  = 50;
  localparam int RDB = 8;
  localparam int SB  = 4;
  localparam int WB  = 10;
  localparam int PW  = 6;
`ifdef SEED_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  // Read A,A,G,G,C,C,A,G packed base 0 in the low bits.
  localparam logic [15:0] PAT = 16'h4A50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  initial forever #5 clk = ~clk;

  logic [2*RB-1:0]  ref_in;
  logic [2*RDB-1:0] read_in;
  logic load, query;

  logic busy_a, ready_a, hit_valid_a, done_a, overflow_a;
  logic [PW-1:0] hit_pos_a;
  logic [2*WB-1:0] hit_seq_a;
  logic [7:0] hit_count_a;
  logic [2:0] dbg_state_a;

  logic busy_b, ready_b, hit_valid_b, done_b, overflow_b;
  logic [PW-1:0] hit_pos_b;
  logic [2*WB-1:0] hit_seq_b;
  logic [7:0] hit_count_b;
  logic [2:0] dbg_state_b;

  seed_index_aligner u_dut_a (
    .clk(clk), .reset(reset), .ref_in(ref_in), .read_in(read_in),
    .load(load), .query(query), .busy(busy_a), .ready(ready_a),
    .hit_valid(hit_valid_a), .hit_pos(hit_pos_a), .hit_seq(hit_seq_a),
    .hit_count(hit_count_a), .done(done_a), .overflow(overflow_a),
    .dbg_state(dbg_state_a)
  );

  seed_index_aligner #(.BKT_DEPTH(16)) u_dut_b (
    .clk(clk), .reset(reset), .ref_in(ref_in), .read_in(read_in),
    .load(load), .query(query), .busy(busy_b), .ready(ready_b),
    .hit_valid(hit_valid_b), .hit_pos(hit_pos_b), .hit_seq(hit_seq_b),
    .hit_count(hit_count_b), .done(done_b), .overflow(overflow_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q_a[$];
  logic [PW-1:0] exp_q_b[$];
  int exp_cnt_a = 0, exp_cnt_b = 0;
  int exp_cyc_a = 0, exp_cyc_b = 0;
  int exp_hits_a = 0, exp_hits_b = 0;
  logic [2*RB-1:0]  cur_ref = '0;
  logic [2*RDB-1:0] cur_read = '0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bucket contents are the positions of each base in ascending order,
  // truncated to the bucket depth; a search walks offsets then bucket order.
  task automatic model_query(input int which, input int depth);
    bit seen [RB];
    int n, cyc, hits;
    logic [1:0] b;
    logic [7:0] rs;
    logic [PW-1:0] hp;
    cyc = 0;
    hits = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int o = 0; o <= RDB - SB; o++) begin
      b  = cur_read[2*o +: 2];
      rs = cur_read[2*o +: 8];
      n  = 0;
      for (int p = 0; p <= RB - SB; p++) begin
        if (cur_ref[2*p +: 2] == b) begin
          n++;
          if (n <= depth && cur_ref[2*p +: 8] == rs && p >= o && (p - o) <= RB - WB) begin
            if (!DEDUP || !seen[p-o]) begin
              hp = PW'(p - o);
              hits++;
              if (which == 0) exp_q_a.push_back(hp);
              else            exp_q_b.push_back(hp);
            end
            seen[p-o] = 1'b1;
          end
        end
      end
      cyc += (n == 0) ? 1 : ((n < depth) ? n : depth);
    end
    if (which == 0) begin
      exp_hits_a = hits; exp_cnt_a = (hits > 255) ? 255 : hits; exp_cyc_a = cyc;
    end else begin
      exp_hits_b = hits; exp_cnt_b = (hits > 255) ? 255 : hits; exp_cyc_b = cyc;
    end
  endtask

  function automatic logic model_overflow(input int depth);
    int n [4];
    logic ovf;
    foreach (n[i]) n[i] = 0;
    for (int p = 0; p <= RB - SB; p++) n[cur_ref[2*p +: 2]]++;
    ovf = 1'b0;
    foreach (n[i]) if (n[i] > depth) ovf = 1'b1;
    return ovf;
  endfunction

  function automatic logic [2*RB-1:0] ref_with_pat(input int start);
    logic [2*RB-1:0] r;
    r = '1;
    r[2*start +: 16] = PAT;
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [PW-1:0] ep;
    if (hit_valid_a) begin
      check_eq("hit_expected_a", exp_q_a.size() > 0, 1);
      if (exp_q_a.size() > 0) begin
        ep = exp_q_a.pop_front();
        check_eq("hit_pos_a", hit_pos_a, ep);
        check_eq("hit_seq_a", hit_seq_a, cur_ref[2*ep +: 2*WB]);
      end
    end
    if (hit_valid_b) begin
      check_eq("hit_expected_b", exp_q_b.size() > 0, 1);
      if (exp_q_b.size() > 0) begin
        ep = exp_q_b.pop_front();
        check_eq("hit_pos_b", hit_pos_b, ep);
        check_eq("hit_seq_b", hit_seq_b, cur_ref[2*ep +: 2*WB]);
      end
    end
    if (done_a) begin
      check_eq("hit_count_a", hit_count_a, exp_cnt_a);
      check_eq("missed_hits_a", exp_q_a.size(), 0);
    end
    if (done_b) begin
      check_eq("hit_count_b", hit_count_b, exp_cnt_b);
      check_eq("missed_hits_b", exp_q_b.size(), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_load(input logic [2*RB-1:0] r, input logic with_query);
    @(negedge clk);
    ref_in = r;
    load   = 1'b1;
    query  = with_query;
    @(negedge clk);
    load   = 1'b0;
    query  = 1'b0;
    cur_ref = r;
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  task automatic wait_build(input int c0);
    int c, ca, cb;
    logic saw_done;
    c = c0; ca = -1; cb = -1; saw_done = 1'b0;
    while ((ca < 0 || cb < 0) && c < 400) begin
      @(negedge clk);
      c++;
      if (ready_a && ca < 0) ca = c;
      if (ready_b && cb < 0) cb = c;
      if (done_a || done_b) saw_done = 1'b1;
    end
    check_eq("build_cycles_a", ca, RB - SB + 1);
    check_eq("build_cycles_b", cb, RB - SB + 1);
    check_eq("done_during_build", saw_done, 0);
    check_eq("overflow_a", overflow_a, model_overflow(64));
    check_eq("overflow_b", overflow_b, model_overflow(16));
  endtask

  task automatic start_query(input logic [2*RDB-1:0] rd);
    @(negedge clk);
    read_in  = rd;
    cur_read = rd;
    exp_q_a.delete();
    exp_q_b.delete();
    model_query(0, 64);
    model_query(1, 16);
    query = 1'b1;
    @(negedge clk);
    query = 1'b0;
  endtask

  task automatic wait_done();
    int c, da, db;
    c = 0; da = -1; db = -1;
    while ((da < 0 || db < 0) && c < 1000) begin
      @(negedge clk);
      c++;
      if (done_a && da < 0) da = c;
      if (done_b && db < 0) db = c;
    end
    check_eq("search_cycles_a", da, exp_cyc_a);
    check_eq("search_cycles_b", db, exp_cyc_b);
    @(negedge clk);
    check_eq("ready_after_done_a", ready_a, 1);
    check_eq("ready_after_done_b", ready_b, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; load = 1'b0; query = 1'b0; ref_in = '0; read_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_ready", ready_a, 0);
    check_eq("rst_hit_valid", hit_valid_a, 0);
    check_eq("rst_hit_pos", hit_pos_a, 0);
    check_eq("rst_hit_seq", hit_seq_a, 0);
    check_eq("rst_hit_count", hit_count_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_overflow", overflow_a, 0);
    check_eq("rst_busy_b", busy_b, 0);
    reset = 1'b1;

    // query in IDLE is ignored
    @(negedge clk); query = 1'b1;
    @(negedge clk); query = 1'b0;
    @(negedge clk);
    check_eq("idle_query_ignored", busy_a | ready_a, 0);

    // all-A reference, all-A read
    pulse_load('0, 1'b0);
    wait_build(0);
    check_eq("allA_overflow_b_lit", overflow_b, 1);
    start_query('0);
    check_eq("model_hits_a_lit", exp_hits_a, DEDUP ? 41 : 205);
    check_eq("model_hits_b_lit", exp_hits_b, DEDUP ? 16 : 70);
    check_eq("model_cyc_a_lit", exp_cyc_a, 235);
    check_eq("model_cyc_b_lit", exp_cyc_b, 80);
    wait_done();
    check_eq("allA_count_a_lit", hit_count_a, DEDUP ? 41 : 205);
    check_eq("allA_count_b_lit", hit_count_b, DEDUP ? 16 : 70);
    check_eq("allA_last_pos_a", hit_pos_a, 40);
    repeat (3) @(negedge clk);
    check_eq("allA_count_hold_a", hit_count_a, exp_cnt_a);

    // reset in the middle of a search
    start_query('0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy_a", busy_a, 0);
    check_eq("midrst_busy_b", busy_b, 0);
    check_eq("midrst_count_a", hit_count_a, 0);
    check_eq("midrst_done_a", done_a, 0);
    check_eq("midrst_overflow_b", overflow_b, 0);
    exp_q_a.delete();
    exp_q_b.delete();
    reset = 1'b1;
    @(negedge clk); query = 1'b1;
    @(negedge clk); query = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("postrst_query_ignored", busy_a | ready_a | done_a, 0);

    // pattern at 20, with a query pulse during the build that must be dropped
    pulse_load(ref_with_pat(20), 1'b0);
    @(negedge clk); query = 1'b1; read_in = PAT;
    @(negedge clk); query = 1'b0;
    wait_build(2);
    repeat (3) @(negedge clk);
    check_eq("build_query_ignored", {busy_a, ready_a}, 2'b01);
    start_query(PAT);
    check_eq("model_pat_hits_lit", exp_hits_a, DEDUP ? 1 : 5);
    wait_done();
    check_eq("pat_hit_pos_lit", hit_pos_a, 20);
    check_eq("pat_hit_seq_lit", hit_seq_a, 20'hF4A50);
    check_eq("pat_count_lit", hit_count_a, DEDUP ? 1 : 5);

    // load during a search aborts it without a done pulse
    start_query(PAT);
    repeat (5) @(negedge clk);
    pulse_load(ref_with_pat(42), 1'b0);
    wait_build(0);

    // load and query together in READY: the load wins
    pulse_load(ref_with_pat(42), 1'b1);
    wait_build(0);

    // pattern too close to the end for a full window: no hits
    start_query(PAT);
    check_eq("model_tail_hits_lit", exp_hits_a, 0);
    wait_done();
    check_eq("tail_count_lit", hit_count_a, 0);
    check_eq("tail_count_b_lit", hit_count_b, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
